mole_scheduler: RTL and testbench
=================================

// Module: mole_scheduler
// PURPOSE
//   Game sequencer for whack-a-mole: runs IDLE/RUN/OVER game flow off the start button, picks the active hole
//   (0..15, one per 4x4 keypad key) via LFSR, times mole visibility, judges keypad hits, keeps score/countdown.
//   Sits between keypad scanner (key_en/key_index) and video renderer (mole_mask/score/time_left); pixel clock domain.
// PARAMETERS
//   TICK_DIV        742500  clk cycles per game tick (10 ms at 74.25 MHz)
//   TICKS_PER_SEC   100     game ticks per countdown second
//   GAME_SECONDS    60      countdown start value (1..255)
//   MOLE_LIFE_TICKS 100     ticks a mole stays up before timing out (>=1)
//   GAP_TICKS       20      ticks with no mole between moles (>=1)
//   SCORE_W         8       score width
//   LFSR_SEED       16'hACE1 LFSR reset value (non-zero)
//   SPEEDUP_STEP    5       ticks removed from life per 4 points (MOLE_SPEEDUP_EN only)
//   MIN_LIFE_TICKS  30      life floor (MOLE_SPEEDUP_EN only)
// PORTS
//   clk        in   1        pixel clock
//   rst        in   1        synchronous, active-high reset
//   start      in   1        start button level (already debounced); rising edge acts
//   key_en     in   1        one-cycle strobe: key_index valid
//   key_index  in   4        pressed key 0..15
//   mole_mask  out  16       one-hot visible mole, 0 when none
//   score      out  SCORE_W  hits this game, saturating
//   time_left  out  8        seconds remaining
//   game_state out  2        0 IDLE, 1 RUN, 2 OVER
//   hit_pulse  out  1        one cycle per correct hit
//   miss_pulse out  1        one cycle per wrong key or timeout
// BEHAVIOUR
//   Reset: state IDLE, mole_mask 0, score 0, time_left GAME_SECONDS, pulses 0, lfsr LFSR_SEED, prescaler 0.
//   start edge: start_q registered; edge = start & ~start_q. Edge in IDLE or OVER -> RUN/GAP next cycle,
//     score 0, time_left GAME_SECONDS, tick/second counters cleared. Edge in RUN ignored.
//   Tick: prescaler 0..TICK_DIV-1, tick strobe on wrap; only counts in RUN. Every TICKS_PER_SEC ticks time_left-1.
//   RUN substates: GAP (mask 0, count GAP_TICKS ticks) -> UP (mask one-hot idx, count life ticks) -> GAP.
//   Hole pick on GAP->UP: idx = lfsr[3:0]; if idx == prev idx then idx+1 mod 16 (15 wraps to 0). LFSR 16-bit
//     Galois, taps x^16+x^14+x^13+x^11, advances every clk regardless of state.
//   In UP, key_en & key_index==idx: score+1 (hold at all-ones), hit_pulse, mask 0, -> GAP same edge.
//   In UP, key_en & key_index!=idx: miss_pulse, mole stays up, life counter unaffected.
//   In UP, life count expires with no hit: miss_pulse, -> GAP. Hit and expiry same cycle: hit wins.
//   key_en in GAP, IDLE, OVER: ignored, no pulses.
//   time_left reaching 0 -> OVER on the same edge: mask 0, score frozen. Hit in that cycle still scores.
//   Outputs registered; key_en to hit_pulse/score/mask update = 1 cycle latency.
//   rst mid-game: immediate return to reset values, no pulses emitted.
// CONFIGURATION
//   MOLE_SPEEDUP_EN defined: life = max(MIN_LIFE_TICKS, MOLE_LIFE_TICKS - (score>>2)*SPEEDUP_STEP), sampled
//     on GAP->UP (constant while mole is up). Undefined: life is always MOLE_LIFE_TICKS; SPEEDUP params unused.
// STRUCTURE
//   Package mole_pkg: game_state encodings (IDLE/RUN/OVER), RUN substate enum (GAP/UP), NUM_HOLES=16,
//     LFSR tap constant.
//   Sub-module mole_tick_gen: prescaler + seconds counter with clear/enable, outputs tick and sec strobes.
//   Top holds FSM, LFSR, hole pick, life/gap counter, score.
// TESTING  (bench params TICK_DIV=4, TICKS_PER_SEC=10, GAME_SECONDS=3, MOLE_LIFE_TICKS=5, GAP_TICKS=2)
//   Reset then start edge -> game_state 1, time_left 3, score 0, mask 0 for 2 ticks then one-hot mole.
//   key_en with matching index while UP -> next cycle hit_pulse=1, score=1, mask=0; GAP follows.
//   key_en with wrong index while UP -> miss_pulse=1, score unchanged, same mole still up.
//   No key for 5 ticks in UP -> miss_pulse=1, mask 0; next mole idx differs from previous (force lfsr[3:0] repeat).
//   Run 30 ticks -> time_left 3->0, game_state 2, mask 0; key_en now yields no pulse; start edge restarts, score 0.
//   Score forced to 8'hFF then hit -> score stays 8'hFF, hit_pulse=1; rst mid-UP -> all outputs at reset values.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared encodings and helpers for the whack-a-mole game sequencer.
package mole_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_RUN  = 2'd1,
    GS_OVER = 2'd2
  } game_state_e;

  typedef enum logic {
    SUB_GAP = 1'b0,
    SUB_UP  = 1'b1
  } run_sub_e;

  localparam int          NUM_HOLES = 16;
  // Galois feedback for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Never show the same hole twice in a row; 15 wraps to 0.
  function automatic logic [3:0] pick_hole(input logic [3:0] cand, input logic [3:0] prev);
    return (cand == prev) ? cand + 4'd1 : cand;
  endfunction

endpackage

// File: rtl/mole_tick_gen.sv
// Game tick prescaler and ticks-per-second counter; strobes are combinational
// and only fire while enabled, a clear returns both counters to zero.
module mole_tick_gen #(
  parameter int TICK_DIV      = 742500,
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o,
  output logic sec_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] TCNT_MAX  = SW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] tcnt_q, tcnt_d;

  assign tick_o = en_i & (presc_q == PRESC_MAX);
  assign sec_o  = tick_o & (tcnt_q == TCNT_MAX);

  always_comb begin
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    if (clr_i) begin
      presc_d = '0;
      tcnt_d  = '0;
    end else if (en_i) begin
      presc_d = tick_o ? '0 : presc_q + PW'(1);
      if (tick_o) begin
        tcnt_d = sec_o ? '0 : tcnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: game flow, hole pick, mole timing, hit judging.
// Optional MOLE_SPEEDUP_EN shortens mole life as the score rises.
//
//   state    | meaning
//   IDLE     | waiting for first start edge after reset
//   RUN/GAP  | game running, no mole visible, counting gap ticks
//   RUN/UP   | game running, one mole visible, counting life ticks
//   OVER     | countdown expired, score frozen until next start edge
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          TICK_DIV        = 742500,
  parameter int          TICKS_PER_SEC   = 100,
  parameter int          GAME_SECONDS    = 60,
  parameter int          MOLE_LIFE_TICKS = 100,
  parameter int          GAP_TICKS       = 20,
`ifdef MOLE_SPEEDUP_EN
  parameter int          SPEEDUP_STEP    = 5,
  parameter int          MIN_LIFE_TICKS  = 30,
`endif
  parameter int          SCORE_W         = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               key_en,
  input  logic [3:0]         key_index,
  output logic [15:0]        mole_mask,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic [1:0]         game_state,
  output logic               hit_pulse,
  output logic               miss_pulse
);

`ifdef MOLE_SPEEDUP_EN
  localparam int LIFE_MAX = (MIN_LIFE_TICKS > MOLE_LIFE_TICKS) ? MIN_LIFE_TICKS : MOLE_LIFE_TICKS;
`else
  localparam int LIFE_MAX = MOLE_LIFE_TICKS;
`endif
  localparam int CNT_MAX = (LIFE_MAX > GAP_TICKS) ? LIFE_MAX : GAP_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_TICKS);

  game_state_e        state_q, state_d;
  run_sub_e           sub_q, sub_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         time_q, time_d;
  logic [15:0]        mask_q, mask_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               start_q;

  logic               start_edge;
  logic               tick_clr;
  logic               tick;
  logic               sec;
  logic [3:0]         next_idx;
  logic [CW-1:0]      life_ticks;

  mole_tick_gen #(
    .TICK_DIV      (TICK_DIV),
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .en_i   (state_q == GS_RUN),
    .tick_o (tick),
    .sec_o  (sec)
  );

`ifdef MOLE_SPEEDUP_EN
  int life_raw;
  // Sampled only on GAP->UP, so a hit during UP cannot change the running mole.
  always_comb begin
    life_raw   = MOLE_LIFE_TICKS - int'(score_q >> 2) * SPEEDUP_STEP;
    life_ticks = (life_raw < MIN_LIFE_TICKS) ? CW'(MIN_LIFE_TICKS) : CW'(life_raw);
  end
`else
  assign life_ticks = CW'(MOLE_LIFE_TICKS);
`endif

  assign start_edge = start & ~start_q;
  assign next_idx   = pick_hole(lfsr_q[3:0], idx_q);

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    score_d  = score_q;
    time_d   = time_q;
    mask_d   = mask_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    tick_clr = 1'b0;
    lfsr_d   = lfsr_next(lfsr_q);

    unique case (state_q)
      GS_IDLE, GS_OVER: begin
        if (start_edge) begin
          state_d  = GS_RUN;
          sub_d    = SUB_GAP;
          cnt_d    = GAP_LOAD;
          score_d  = '0;
          time_d   = 8'(GAME_SECONDS);
          mask_d   = '0;
          tick_clr = 1'b1;
        end
      end

      GS_RUN: begin
        if (sub_q == SUB_UP) begin
          if (key_en && (key_index == idx_q)) begin
            hit_d   = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            mask_d  = '0;
            sub_d   = SUB_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            if (key_en) begin
              miss_d = 1'b1;
            end
            if (tick) begin
              if (cnt_q == CW'(1)) begin
                miss_d = 1'b1;
                mask_d = '0;
                sub_d  = SUB_GAP;
                cnt_d  = GAP_LOAD;
              end else begin
                cnt_d = cnt_q - CW'(1);
              end
            end
          end
        end else if (tick) begin
          if (cnt_q == CW'(1)) begin
            sub_d  = SUB_UP;
            idx_d  = next_idx;
            mask_d = 16'h0001 << next_idx;
            cnt_d  = life_ticks;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end

        // Countdown end overrides the mole but keeps any hit scored this cycle.
        if (sec) begin
          time_d = time_q - 8'd1;
          if (time_q == 8'd1) begin
            state_d = GS_OVER;
            sub_d   = SUB_GAP;
            mask_d  = '0;
            idx_d   = idx_q;
          end
        end
      end

      default: state_d = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GS_IDLE;
      sub_q   <= SUB_GAP;
      cnt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
      time_q  <= 8'(GAME_SECONDS);
      mask_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      time_q  <= time_d;
      mask_q  <= mask_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      start_q <= start;
    end
  end

  assign mole_mask  = mask_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign game_state = state_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler; a second instance with a 2-bit score
// shares all inputs so score saturation is reached within one short game.
module tb_mole_scheduler;

  localparam int TICK_DIV = 4;
  localparam int TPS      = 10;
  localparam int GSEC     = 3;
  localparam int LIFE     = 5;
  localparam int GAP      = 2;

  logic        clk = 1'b0;
  logic        rst, start, key_en;
  logic [3:0]  key_index;
  logic [15:0] mole_mask, s_mole_mask;
  logic [7:0]  score, time_left, s_time_left;
  logic [1:0]  s_score;
  logic [1:0]  game_state, s_game_state;
  logic        hit_pulse, miss_pulse, s_hit_pulse, s_miss_pulse;

  always #5 clk = ~clk;

  mole_scheduler #(
    .TICK_DIV(TICK_DIV), .TICKS_PER_SEC(TPS), .GAME_SECONDS(GSEC),
    .MOLE_LIFE_TICKS(LIFE), .GAP_TICKS(GAP), .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key_en(key_en), .key_index(key_index),
    .mole_mask(mole_mask), .score(score), .time_left(time_left),
    .game_state(game_state), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  mole_scheduler #(
    .TICK_DIV(TICK_DIV), .TICKS_PER_SEC(TPS), .GAME_SECONDS(GSEC),
    .MOLE_LIFE_TICKS(LIFE), .GAP_TICKS(GAP), .SCORE_W(2), .LFSR_SEED(16'hACE1)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start), .key_en(key_en), .key_index(key_index),
    .mole_mask(s_mole_mask), .score(s_score), .time_left(s_time_left),
    .game_state(s_game_state), .hit_pulse(s_hit_pulse), .miss_pulse(s_miss_pulse)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11, Galois, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [3:0] nib_after8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = lfsr_step(t);
    return t[3:0];
  endfunction

  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= rst ? 16'hACE1 : lfsr_step(m_lfsr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        hit;
    logic        miss;
    logic [7:0]  score;
    logic [1:0]  s_score;
    logic [15:0] mask;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_prev_idx, cur_idx;
  logic [7:0] m_score;
  logic [1:0] m_sscore;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // up: a mole is visible; end_now: countdown ends on this edge.
  task automatic key_step(input string tag, input logic [3:0] k, input logic up, input logic end_now);
    exp_t e, g;
    e.tag  = tag;
    e.hit  = up && (k == cur_idx);
    e.miss = up && !e.hit;
    if (e.hit) begin
      m_score  = (m_score == 8'hFF) ? m_score : m_score + 8'd1;
      m_sscore = (m_sscore == 2'd3) ? m_sscore : m_sscore + 2'd1;
    end
    e.score   = m_score;
    e.s_score = m_sscore;
    e.mask    = (up && !e.hit && !end_now) ? (16'h0001 << cur_idx) : 16'h0000;
    key_en    = 1'b1;
    key_index = k;
    sb.push_back(e);
    step();
    key_en = 1'b0;
    g = sb.pop_front();
    chk({g.tag, "_hit"},     hit_pulse,   g.hit);
    chk({g.tag, "_miss"},    miss_pulse,  g.miss);
    chk({g.tag, "_score"},   score,       g.score);
    chk({g.tag, "_mask"},    mole_mask,   g.mask);
    chk({g.tag, "_s_score"}, s_score,     g.s_score);
    chk({g.tag, "_s_hit"},   s_hit_pulse, g.hit);
  endtask

  task automatic wait_mole(input string tag, output int n);
    logic [3:0] exp_idx;
    n = 0;
    while (mole_mask == 16'h0000 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, mole_mask != 16'h0000, 1'b1);
    exp_idx = (m_lfsr_prev[3:0] == m_prev_idx) ? m_lfsr_prev[3:0] + 4'd1 : m_lfsr_prev[3:0];
    chk({tag, "_idx"}, mole_mask, 16'h0001 << exp_idx);
    chk({tag, "_new"}, mole_mask != (16'h0001 << m_prev_idx), 1'b1);
    m_prev_idx = exp_idx;
    cur_idx    = exp_idx;
  endtask

  initial begin
    int n;
    int guard;
    rst = 1'b1; start = 1'b0; key_en = 1'b0; key_index = 4'd0;
    m_prev_idx = 4'd0; cur_idx = 4'd0; m_score = 8'd0; m_sscore = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", game_state, 2'd0);
    chk("rst_mask",  mole_mask,  16'h0000);
    chk("rst_score", score,      8'd0);
    chk("rst_time",  time_left,  8'd3);
    chk("rst_hit",   hit_pulse,  1'b0);
    chk("rst_miss",  miss_pulse, 1'b0);
    rst = 1'b0;

    // Time the start so the first pick sees lfsr[3:0]==0, repeating the reset hole 0.
    guard = 0;
    while (nib_after8(m_lfsr) != 4'd0 && guard < 1000) begin
      step();
      guard++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_state", game_state, 2'd1);
    chk("start_time",  time_left,  8'd3);
    chk("start_score", score,      8'd0);
    chk("start_mask",  mole_mask,  16'h0000);
    steps(7);
    chk("gap_hold", mole_mask, 16'h0000);
    wait_mole("mole1", n);
    chk("mole1_lat", n, 1);
    chk("repeat_bump", mole_mask, 16'h0002);

    key_step("hit1", cur_idx, 1'b1, 1'b0);
    wait_mole("mole2", n);
    chk("mole2_lat", n, 7);
    key_step("wrong", cur_idx + 4'd1, 1'b1, 1'b0);
    steps(18);
    chk("still_up",   mole_mask,  16'h0001 << cur_idx);
    chk("still_miss", miss_pulse, 1'b0);
    step();
    chk("tmo_miss", miss_pulse, 1'b1);
    chk("tmo_hit",  hit_pulse,  1'b0);
    chk("tmo_mask", mole_mask,  16'h0000);
    chk("tmo_score", score,     8'd1);

    wait_mole("mole3", n);
    chk("mole3_lat", n, 8);
    chk("time_2", time_left, 8'd2);
    for (int h = 0; h < 4; h++) begin
      key_step("hit_run", cur_idx, 1'b1, 1'b0);
      wait_mole("mole_run", n);
      chk("mole_run_lat", n, 7);
    end

    steps(19);
    chk("time_1", time_left, 8'd1);
    key_step("hit_expire", cur_idx, 1'b1, 1'b0);
    key_step("gap_key", 4'd3, 1'b0, 1'b0);
    wait_mole("mole_last", n);
    chk("mole_last_lat", n, 7);
    steps(15);
    chk("pre_end_state", game_state, 2'd1);
    key_step("hit_end", cur_idx, 1'b1, 1'b1);
    chk("end_state", game_state, 2'd2);
    chk("end_time",  time_left,  8'd0);
    key_step("over_key", 4'd0, 1'b0, 1'b0);
    steps(10);
    chk("over_state", game_state, 2'd2);
    chk("over_score", score,      8'd7);
    chk("over_mask",  mole_mask,  16'h0000);

    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 8'd0; m_sscore = 2'd0;
    chk("restart_state",   game_state, 2'd1);
    chk("restart_score",   score,      8'd0);
    chk("restart_s_score", s_score,    2'd0);
    chk("restart_time",    time_left,  8'd3);
    wait_mole("mole_g2", n);
    chk("mole_g2_lat", n, 8);

    rst = 1'b1; key_en = 1'b1; key_index = cur_idx;
    step();
    rst = 1'b0; key_en = 1'b0;
    chk("mid_rst_state", game_state, 2'd0);
    chk("mid_rst_mask",  mole_mask,  16'h0000);
    chk("mid_rst_score", score,      8'd0);
    chk("mid_rst_time",  time_left,  8'd3);
    chk("mid_rst_hit",   hit_pulse,  1'b0);
    chk("mid_rst_miss",  miss_pulse, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
